reg_mem_arbiter: RTL

- Two-requester round-robin arbiter and sequencer in front of one reg_mem instance (single port: addr, data_in, wen, clk, data_out).
- Serialises read/write transactions from requester 0 and requester 1 onto the memory port.
- Owns the memory timing and returns read data and a completion ack per requester.
- Sits between the reg_mem and its two clients, e.g. a control FSM and a fill/readout engine.

---
 rtl/reg_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/reg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_mem_arbiter
// Function : Two-requester round-robin arbiter/sequencer for one reg_mem port.
//            Optional power-up zero sweep enabled by REG_MEM_ARB_CLEAR_EN.
// Revision : 1.0
// ============================================================================
module reg_mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_RDWAIT = 3'd2,
    S_RESP   = 3'd3,
    S_CLEAR  = 3'd4
  } state_t;

`ifdef REG_MEM_ARB_CLEAR_EN
  localparam state_t                 C_RESET_STATE = S_CLEAR;
  localparam logic [ADDR_BITS-1:0]   C_LAST_ADDR   = '1;
`else
  localparam state_t                 C_RESET_STATE = S_IDLE;
`endif

  state_t                r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_we;

  logic                  w_any_req;
  logic                  w_sel;
  logic                  w_sel_we;
  logic [ADDR_BITS-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    w_any_req   = req0 | req1;
    w_sel       = (req0 && req1) ? ~r_last_grant : req1;
    w_sel_we    = w_sel ? we1    : we0;
    w_sel_addr  = w_sel ? addr1  : addr0;
    w_sel_wdata = w_sel ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_RESET_STATE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_we         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wen      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_sel;
            r_last_grant <= w_sel;
            r_we         <= w_sel_we;
            mem_addr     <= w_sel_addr;
            mem_wdata    <= w_sel_wdata;
            mem_wen      <= w_sel_we;
            busy         <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_wen <= 1'b0;
          if (r_we) begin
            // Ack is registered, so it is raised on entry to RESP.
            if (r_grant) ack1 <= 1'b1;
            else         ack0 <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_state <= S_RDWAIT;
          end
        end
        S_RDWAIT: begin
          if (r_grant) begin
            rdata1 <= mem_rdata;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= mem_rdata;
            ack0   <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
`ifdef REG_MEM_ARB_CLEAR_EN
        S_CLEAR: begin
          // mem_wen low marks the first cycle after reset: start the sweep.
          mem_wdata <= '0;
          if (!mem_wen) begin
            mem_wen  <= 1'b1;
            mem_addr <= '0;
            busy     <= 1'b1;
          end else if (mem_addr == C_LAST_ADDR) begin
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
`endif
        default: begin
          mem_wen <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
